// File: rtl/sipo_sb_pkg.sv
// Shared definitions for the serial-bus deserialiser.
// Holds parameter defaults and the counter-width helper.
package sipo_sb_pkg;

   localparam int WIDTH_DEF     = 384;
   localparam bit LSB_FIRST_DEF = 1'b1;

   // Bit-counter width: enough bits to count 0..w-1.
   function automatic int sb_cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/sipo_shift_core_sb.sv
// Serial shift register and bit counter for the SB deserialiser.
// Flags the cycle in which the last bit of a frame is sampled.
module sipo_shift_core_sb
   import sipo_sb_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter bit LSB_FIRST = LSB_FIRST_DEF,
   localparam int CW       = sb_cnt_width(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             dat_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] word_o,
   output logic             done_o,
   output logic [CW-1:0]    cnt_o
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q, sr_d, sr_sh;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Shifted value including the incoming bit; also the completed word.
   always_comb begin
      if (LSB_FIRST) begin
         sr_sh = {dat_i, sr_q[WIDTH-1:1]};
      end else begin
         sr_sh = {sr_q[WIDTH-2:0], dat_i};
      end
   end

   // Clear wins over shift; the counter wraps on the last bit of a frame.
   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      done_o = 1'b0;
      if (clr_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (en_i) begin
         sr_d = sr_sh;
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            done_o = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Shift register and counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign word_o = sr_sh;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/sipo_frame_sb.sv
// SB serial-in/parallel-out deserialiser top level.
// Adds the holding register, valid/ready drain and sticky overflow.
module sipo_frame_sb
   import sipo_sb_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter bit LSB_FIRST = LSB_FIRST_DEF,
   localparam int CW       = sb_cnt_width(WIDTH)
) (
   input  logic             CLOCK_SB,
   input  logic             RES_SB,
   input  logic             EN_SB,
   input  logic             DAT_IN_SB,
   input  logic             CLR_SB,
   output logic [WIDTH-1:0] DAT_OUT_SB,
   output logic             VLD_SB,
   input  logic             RDY_SB,
   output logic [CW-1:0]    CNT_SB,
   output logic             BUSY_SB,
   output logic             OVF_SB
);

   logic [WIDTH-1:0] word;
   logic             done;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] dat_q, dat_d;
   logic             vld_q, vld_d;
   logic             ovf_q, ovf_d;

   sipo_shift_core_sb #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_core (
      .clk_i  (CLOCK_SB),
      .rst_ni (RES_SB),
      .en_i   (EN_SB),
      .dat_i  (DAT_IN_SB),
      .clr_i  (CLR_SB),
      .word_o (word),
      .done_o (done),
      .cnt_o  (cnt)
   );

   // Load a finished word if the slot is free or draining now, else drop it.
   always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      ovf_d = ovf_q;
      if (done) begin
         if (!vld_q || RDY_SB) begin
            dat_d = word;
            vld_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (vld_q && RDY_SB) begin
         vld_d = 1'b0;
      end
      if (CLR_SB) begin
         ovf_d = 1'b0;
      end
   end

   // Holding register, valid flag and overflow flag.
   always_ff @(posedge CLOCK_SB or negedge RES_SB) begin
      if (!RES_SB) begin
         dat_q <= '0;
         vld_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         dat_q <= dat_d;
         vld_q <= vld_d;
         ovf_q <= ovf_d;
      end
   end

   assign DAT_OUT_SB = dat_q;
   assign VLD_SB     = vld_q;
   assign OVF_SB     = ovf_q;
   assign CNT_SB     = cnt;
   assign BUSY_SB    = (cnt != '0);

endmodule

// File: doc/sipo_frame_sb.md
# sipo_frame_sb

Parametrised serial-in/parallel-out deserialiser for the serial-bus (SB) data path. It assembles WIDTH serial bits into a word and tracks frame position with an internal bit counter. Completed words go to a holding register that a downstream consumer drains over a valid/ready handshake. Overruns are detected, not silently overwritten, so the block can sit between a free-running serial source and a stalling parallel consumer.

## Interface
- WIDTH, 384, bits per frame; legal range 2..1024
- LSB_FIRST, 1, 1 = first received bit lands in DAT_OUT_SB[0]; 0 = first received bit lands in DAT_OUT_SB[WIDTH-1]
- CW, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports (one clock; reset is asynchronous and active-low):
- CLOCK_SB  in  1  sole clock, rising edge
- RES_SB  in  1  asynchronous, active-low reset
- EN_SB  in  1  serial bit strobe; DAT_IN_SB sampled when high
- DAT_IN_SB  in  1  serial data bit
- CLR_SB  in  1  synchronous abort of the partial frame; clears OVF_SB
- DAT_OUT_SB  out  WIDTH  holding register, stable while VLD_SB=1
- VLD_SB  out  1  holding register contains an unconsumed word
- RDY_SB  in  1  consumer accepts the word when VLD_SB&RDY_SB
- CNT_SB  out  CW  bits received in the current frame, 0..WIDTH-1
- BUSY_SB  out  1  CNT_SB != 0
- OVF_SB  out  1  sticky: a completed frame was dropped

## Operation
- Reset (RES_SB=0, asynchronous): shift register, DAT_OUT_SB, CNT_SB, VLD_SB and OVF_SB all go to 0. Release is synchronous to CLOCK_SB.
- Shift, EN_SB=1:
  - LSB_FIRST=1: sr <= {DAT_IN_SB, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], DAT_IN_SB}.
  - CNT_SB increments in both cases.
- Frame complete: EN_SB=1 while CNT_SB==WIDTH-1.
  - The word is the shifted value including the current bit.
  - CNT_SB wraps to 0.
  - The shift register keeps shifting; no clear is needed.
- Load of the holding register on frame complete:
  - If VLD_SB=0, or VLD_SB&RDY_SB in the same cycle: DAT_OUT_SB <= word and VLD_SB <= 1.
  - Otherwise the word is dropped, DAT_OUT_SB is unchanged, and OVF_SB <= 1.
- Drain: VLD_SB&RDY_SB with no load in the same cycle sets VLD_SB <= 0. DAT_OUT_SB keeps its last value.
- CLR_SB=1 takes priority over EN_SB:
  - CNT_SB <= 0, shift register <= 0, OVF_SB <= 0.
  - The bit on DAT_IN_SB in that cycle is discarded.
  - The holding register and VLD_SB are not affected, and a drain in the same cycle still completes.
- EN_SB=0 with CLR_SB=0: shift register and counter hold.
- RDY_SB is ignored while VLD_SB=0.

## Timing
- Latency: VLD_SB rises on the clock edge that samples the WIDTH-th bit, and is visible the following cycle.
- Back-to-back frames at EN_SB=1 every cycle with RDY_SB=1 tied high: no drops. VLD_SB pulses for 1 cycle every WIDTH cycles.
- Minimum consumer response without overflow: the consumer must accept within WIDTH-1 cycles of VLD_SB rising at full bit rate.
- All outputs are registered; there is no combinational path from input to output. In particular, VLD_SB does not depend on RDY_SB combinationally.
- Reset asserted mid-frame discards the partial frame and the held word immediately.

## Structure
- Package sipo_sb_pkg holds:
  - the function computing CW
  - localparam defaults WIDTH_DEF=384 and LSB_FIRST_DEF=1
- Sub-module sipo_shift_core_sb (WIDTH, LSB_FIRST) contains the shift register, the bit counter and the frame-complete pulse.
- The top level adds the holding register, the handshake and the overflow logic.

## Test plan
- Reset, then 8 bits 1,0,1,1,0,0,1,0 with WIDTH=8, LSB_FIRST=1 and RDY_SB=0 -> VLD_SB=1 one cycle after the 8th bit, DAT_OUT_SB=8'h4D, CNT_SB=0. Same stimulus with LSB_FIRST=0 -> 8'hB2.
- WIDTH=384, continuous EN_SB=1, RDY_SB=1, 3 frames of pseudo-random data -> 3 single-cycle VLD_SB pulses 384 cycles apart, each word matching the model, OVF_SB=0.
- WIDTH=8, RDY_SB=0, 2 full frames (A5 then 3C, LSB-first) -> DAT_OUT_SB stays 8'hA5 and OVF_SB=1. Raising RDY_SB then drains A5 and VLD_SB falls.
- WIDTH=8, RDY_SB pulsed in the exact cycle the second frame completes -> first word accepted, DAT_OUT_SB becomes the second word, VLD_SB stays 1, OVF_SB=0.
- CLR_SB after 5 of 8 bits, then 8 fresh bits -> CNT_SB=0 after clear, and the completed word contains only the fresh bits. CLR_SB together with EN_SB -> bit discarded, CNT_SB=0.
- RES_SB asserted asynchronously between edges with CNT_SB=6 and VLD_SB=1 -> all outputs 0 immediately. After release, a new 8-bit frame assembles correctly.
